// File: rtl/uart_rx_word_loader_if.sv
// Byte-stream input, memory write port and load status of the UART word loader.
// The loader takes the master modport; the environment feeding it takes the slave modport.
interface uart_rx_word_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_done_tick;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [15:0]       word_count;

  modport master (
    input  rx_done_tick, rx_byte,
    output mem_we, mem_addr, mem_wdata, load_busy, load_done, load_err, word_count
  );

  modport slave (
    output rx_done_tick, rx_byte,
    input  mem_we, mem_addr, mem_wdata, load_busy, load_done, load_err, word_count
  );
endinterface

// File: rtl/uart_rx_word_loader.sv
// Frames SYNC / 16-bit count / little-endian 32-bit words / XOR checksum from the UART byte
// stream and writes each assembled word through a single-cycle memory write port.
module uart_rx_word_loader #(
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_word_loader_if.master bus
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam int TMO_W     = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_tick_d;
  logic [TMO_W-1:0]  r_tmo;
  logic [1:0]        r_lane;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [15:0]       r_word_count;
  logic              r_mem_we;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_accept;
  logic              w_expire;
  logic [15:0]       w_len_count;
  logic              w_len_too_big;
  logic              w_len_zero;
  logic              w_last_word;

  logic              w_sync;
  logic              w_len_lo;
  logic              w_len_hi;
  logic              w_data_start;
  logic              w_data_byte;
  logic              w_we_set;
  logic              w_done_set;
  logic              w_err_set;
  logic              w_busy;

  // A tick held high for several cycles must deliver only one byte.
  assign w_accept      = bus.rx_done_tick & ~r_tick_d;
  // An accepted byte in the expiry cycle wins over the timeout.
  assign w_expire      = (r_state != S_IDLE) && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CLKS - 1));
  assign w_len_count   = {bus.rx_byte, r_word_count[7:0]};
  assign w_len_too_big = int'(w_len_count) > MAX_WORDS;
  assign w_len_zero    = (w_len_count == 16'd0);
  assign w_last_word   = (32'(r_mem_addr) + 32'd1) == 32'(r_word_count);

  // NOTE: non-blocking assignments in every clocked block so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && bus.rx_byte == SYNC_BYTE) w_state_next = S_LEN_LO;
      S_LEN_LO: if (w_accept) w_state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len_too_big)   w_state_next = S_IDLE;
          else if (w_len_zero) w_state_next = S_CHK;
          else                 w_state_next = S_DATA;
        end
      end
      // Leave DATA only once the final word's write strobe is on the port.
      S_DATA:   if (r_mem_we && w_last_word) w_state_next = S_CHK;
      S_CHK:    if (w_accept) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_expire) w_state_next = S_IDLE;
  end

  always_comb begin
    w_sync       = 1'b0;
    w_len_lo     = 1'b0;
    w_len_hi     = 1'b0;
    w_data_start = 1'b0;
    w_data_byte  = 1'b0;
    w_we_set     = 1'b0;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    w_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   w_sync   = w_accept && (bus.rx_byte == SYNC_BYTE);
      S_LEN_LO: w_len_lo = w_accept;
      S_LEN_HI: begin
        w_len_hi     = w_accept;
        w_err_set    = w_accept && w_len_too_big;
        w_data_start = w_accept && !w_len_too_big && !w_len_zero;
      end
      S_DATA: begin
        w_data_byte = w_accept;
        w_we_set    = w_accept && (r_lane == 2'd3);
      end
      S_CHK: begin
        w_done_set = w_accept && (bus.rx_byte == r_chk);
        w_err_set  = w_accept && (bus.rx_byte != r_chk);
      end
      default: ;
    endcase
    if (w_expire) w_err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_d     <= 1'b0;
      r_tmo        <= '0;
      r_lane       <= '0;
      r_chk        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
      r_mem_we     <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_tick_d    <= bus.rx_done_tick;
      r_mem_we    <= w_we_set;
      r_load_done <= w_done_set;

      if (w_sync)         r_load_err <= 1'b0;
      else if (w_err_set) r_load_err <= 1'b1;

      // The address advances after each write except the last, so it never wraps.
      if (w_sync)                       r_mem_addr <= '0;
      else if (r_mem_we && !w_last_word) r_mem_addr <= r_mem_addr + ADDR_W'(1);

      if (w_len_lo)     r_word_count[7:0]  <= bus.rx_byte;
      if (w_len_hi)     r_word_count[15:8] <= bus.rx_byte;
      if (w_data_start) r_lane <= '0;

      if (w_sync) begin
        r_chk <= '0;
      end else if (w_data_byte) begin
        r_mem_wdata[{r_lane, 3'b000} +: 8] <= bus.rx_byte;
        r_chk  <= r_chk ^ bus.rx_byte;
        r_lane <= r_lane + 2'd1;
      end

      if (r_state == S_IDLE || w_accept || w_expire) r_tmo <= '0;
      else                                           r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.load_busy  = w_busy;
  assign bus.load_done  = r_load_done;
  assign bus.load_err   = r_load_err;
  assign bus.word_count = r_word_count;

endmodule
